// File: rtl/memstage_pkg.sv
// memstage shared definitions: access sizes,
// extension control bit and FSM states.
package memstage_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam int XRS_UNSIGNED = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

endpackage

// File: rtl/memstage_lanes.sv
// Byte-lane steering for the 64-bit data bus:
// store select/replication and load extract/extend.
module mem_lanes
  import memstage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  off,
  input  logic        uns,
  input  logic [63:0] st_dat,
  input  logic [63:0] rd_dat,
  output logic [7:0]  sel,
  output logic [63:0] st_rep,
  output logic [63:0] ld_dat,
  output logic        misal
);

  logic [63:0] sh;

  assign sh = rd_dat >> {off, 3'b000};

  always_comb begin
    sel    = '0;
    st_rep = '0;
    ld_dat = '0;
    misal  = 1'b0;
    unique case (size)
      SZ_B: begin
        sel    = 8'h01 << off;
        st_rep = {8{st_dat[7:0]}};
        ld_dat = uns ? {56'b0, sh[7:0]}
                     : {{56{sh[7]}}, sh[7:0]};
      end
      SZ_H: begin
        sel    = 8'h03 << off;
        st_rep = {4{st_dat[15:0]}};
        ld_dat = uns ? {48'b0, sh[15:0]}
                     : {{48{sh[15]}}, sh[15:0]};
        misal  = off[0];
      end
      SZ_W: begin
        sel    = 8'h0F << off;
        st_rep = {2{st_dat[31:0]}};
        ld_dat = uns ? {32'b0, sh[31:0]}
                     : {{32{sh[31]}}, sh[31:0]};
        misal  = |off[1:0];
      end
      SZ_D: begin
        sel    = 8'hFF;
        st_rep = st_dat;
        ld_dat = sh;
        misal  = |off;
      end
    endcase
  end

endmodule

// File: rtl/memstage.sv
// KCP53K cpu2 memory stage: one Wishbone cycle per
// load/store, registered writeback for ALU and loads.
module memstage
  import memstage_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [4:0]  rd_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] dat_i,
  input  logic        we_i,
  input  logic        mem_i,
  input  logic        nomem_i,
  input  logic [2:0]  xrs_rwe_i,
  output logic        busy_o,
  output logic [63:0] dwb_adr_o,
  output logic [63:0] dwb_dat_o,
  output logic [7:0]  dwb_sel_o,
  output logic        dwb_we_o,
  output logic        dwb_cyc_o,
  output logic        dwb_stb_o,
  input  logic [63:0] dwb_dat_i,
  input  logic        dwb_ack_i,
  input  logic        dwb_err_i,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [63:0] wb_dat_o,
  output logic        fault_o
);

  state_t state_q, state_d;

  logic [4:0]  rd_q;
  logic [1:0]  sz_q;
  logic [2:0]  off_q;
  logic        uns_q;

  logic [1:0]  sz_m;
  logic [2:0]  off_m;
  logic        uns_m;
  logic [7:0]  sel_c;
  logic [63:0] rep_c;
  logic [63:0] ld_c;
  logic        misal_c;

  logic cap_bus, cap_fault, cap_wb;
  logic bus_err, bus_done, ld_done;

  assign busy_o    = (state_q == ST_BUS);
  assign dwb_cyc_o = busy_o;
  assign dwb_stb_o = busy_o;

  // Lanes see the live request in IDLE, the held one in BUS.
  assign sz_m  = busy_o ? sz_q  : xrs_rwe_i[1:0];
  assign off_m = busy_o ? off_q : addr_i[2:0];
  assign uns_m = busy_o ? uns_q : xrs_rwe_i[XRS_UNSIGNED];

  mem_lanes u_lanes (
    .size   (sz_m),
    .off    (off_m),
    .uns    (uns_m),
    .st_dat (dat_i),
    .rd_dat (dwb_dat_i),
    .sel    (sel_c),
    .st_rep (rep_c),
    .ld_dat (ld_c),
    .misal  (misal_c)
  );

  always_comb begin
    state_d   = state_q;
    cap_bus   = 1'b0;
    cap_fault = 1'b0;
    cap_wb    = 1'b0;
    bus_err   = 1'b0;
    bus_done  = 1'b0;
    ld_done   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (we_i || mem_i) begin
          if (misal_c) begin
            cap_fault = 1'b1;
          end else begin
            cap_bus = 1'b1;
            state_d = ST_BUS;
          end
        end else begin
          cap_wb = nomem_i;
        end
      end
      ST_BUS: begin
        if (dwb_err_i) begin
          bus_err  = 1'b1;
          bus_done = 1'b1;
          state_d  = ST_IDLE;
        end else if (dwb_ack_i) begin
          ld_done  = !dwb_we_o;
          bus_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      dwb_adr_o <= '0;
      dwb_dat_o <= '0;
      dwb_sel_o <= '0;
      dwb_we_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_rd_o   <= '0;
      wb_dat_o  <= '0;
      fault_o   <= 1'b0;
      rd_q      <= '0;
      sz_q      <= '0;
      off_q     <= '0;
      uns_q     <= 1'b0;
    end else begin
      wb_we_o <= 1'b0;
      fault_o <= cap_fault | bus_err;
      if (cap_bus) begin
        dwb_adr_o <= {addr_i[63:3], 3'b000};
        dwb_dat_o <= rep_c;
        dwb_sel_o <= sel_c;
        dwb_we_o  <= we_i;
        rd_q      <= rd_i;
        sz_q      <= xrs_rwe_i[1:0];
        off_q     <= addr_i[2:0];
        uns_q     <= xrs_rwe_i[XRS_UNSIGNED];
      end
      if (bus_done) begin
        dwb_sel_o <= '0;
        dwb_we_o  <= 1'b0;
      end
      if (cap_wb) begin
        wb_we_o  <= (rd_i != 5'd0);
        wb_rd_o  <= rd_i;
        wb_dat_o <= addr_i;
      end
      if (ld_done) begin
        wb_we_o  <= (rd_q != 5'd0);
        wb_rd_o  <= rd_q;
        wb_dat_o <= ld_c;
      end
    end
  end

endmodule

// File: tb/tb_memstage.sv
// Self-checking bench for memstage: transaction-level
// model compared every cycle, plus literal pins.
module tb_memstage;
  import memstage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic [4:0]  rd_i = '0;
  logic [63:0] addr_i = '0;
  logic [63:0] dat_i = '0;
  logic        we_i = 1'b0;
  logic        mem_i = 1'b0;
  logic        nomem_i = 1'b0;
  logic [2:0]  xrs_rwe_i = '0;
  logic        busy_o;
  logic [63:0] dwb_adr_o;
  logic [63:0] dwb_dat_o;
  logic [7:0]  dwb_sel_o;
  logic        dwb_we_o;
  logic        dwb_cyc_o;
  logic        dwb_stb_o;
  logic [63:0] dwb_dat_i = '0;
  logic        dwb_ack_i = 1'b0;
  logic        dwb_err_i = 1'b0;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [63:0] wb_dat_o;
  logic        fault_o;

  memstage dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .rd_i      (rd_i),
    .addr_i    (addr_i),
    .dat_i     (dat_i),
    .we_i      (we_i),
    .mem_i     (mem_i),
    .nomem_i   (nomem_i),
    .xrs_rwe_i (xrs_rwe_i),
    .busy_o    (busy_o),
    .dwb_adr_o (dwb_adr_o),
    .dwb_dat_o (dwb_dat_o),
    .dwb_sel_o (dwb_sel_o),
    .dwb_we_o  (dwb_we_o),
    .dwb_cyc_o (dwb_cyc_o),
    .dwb_stb_o (dwb_stb_o),
    .dwb_dat_i (dwb_dat_i),
    .dwb_ack_i (dwb_ack_i),
    .dwb_err_i (dwb_err_i),
    .wb_we_o   (wb_we_o),
    .wb_rd_o   (wb_rd_o),
    .wb_dat_o  (wb_dat_o),
    .fault_o   (fault_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  function automatic logic [7:0] f_sel(input logic [1:0] sz,
                                       input logic [2:0] o);
    int n;
    n = 1 << sz;
    f_sel = '0;
    for (int i = 0; i < 8; i++)
      if (i >= int'(o) && i < int'(o) + n) f_sel[i] = 1'b1;
  endfunction

  function automatic logic [63:0] f_rep(input logic [63:0] d,
                                        input logic [1:0] sz);
    int n;
    n = 1 << sz;
    f_rep = '0;
    for (int i = 0; i < 8; i++)
      f_rep[i*8 +: 8] = d[(i % n)*8 +: 8];
  endfunction

  function automatic logic [63:0] f_ext(input logic [63:0] r,
                                        input logic [1:0] sz,
                                        input logic [2:0] o,
                                        input logic u);
    int n;
    n = 1 << sz;
    f_ext = '0;
    for (int i = 0; i < n; i++)
      if (int'(o) + i < 8) f_ext[i*8 +: 8] = r[(int'(o)+i)*8 +: 8];
    if (!u && f_ext[n*8-1])
      for (int j = n*8; j < 64; j++) f_ext[j] = 1'b1;
  endfunction

  function automatic logic f_mis(input logic [1:0] sz,
                                 input logic [2:0] o);
    int n;
    n = 1 << sz;
    f_mis = (int'(o) % n) != 0;
  endfunction

  // Model state: one pending bus op at most.
  logic        m_pend = 1'b0;
  logic [63:0] m_adr = '0;
  logic [7:0]  m_sel = '0;
  logic        m_we = 1'b0;
  logic [63:0] m_dat = '0;
  logic [4:0]  m_rd = '0;
  logic [1:0]  m_sz = '0;
  logic [2:0]  m_off = '0;
  logic        m_uns = 1'b0;
  logic        m_wbwe = 1'b0;
  logic [4:0]  m_wbrd = '0;
  logic [63:0] m_wbdat = '0;
  logic        m_fault = 1'b0;

  always @(posedge clk) begin
    if (!reset_i) begin
      m_pend = 1'b0;
      m_wbwe = 1'b0;
      m_fault = 1'b0;
      m_wbrd = '0;
      m_wbdat = '0;
    end else begin
      m_wbwe = 1'b0;
      m_fault = 1'b0;
      if (m_pend) begin
        if (dwb_err_i) begin
          m_pend = 1'b0;
          m_fault = 1'b1;
        end else if (dwb_ack_i) begin
          m_pend = 1'b0;
          if (!m_we) begin
            m_wbwe = (m_rd != 0);
            m_wbrd = m_rd;
            m_wbdat = f_ext(dwb_dat_i, m_sz, m_off, m_uns);
          end
        end
      end else if (we_i || mem_i) begin
        if (f_mis(xrs_rwe_i[1:0], addr_i[2:0])) begin
          m_fault = 1'b1;
        end else begin
          m_pend = 1'b1;
          m_sz  = xrs_rwe_i[1:0];
          m_off = addr_i[2:0];
          m_uns = xrs_rwe_i[2];
          m_rd  = rd_i;
          m_we  = we_i;
          m_adr = addr_i & ~64'h7;
          m_sel = f_sel(m_sz, m_off);
          m_dat = f_rep(dat_i, m_sz);
        end
      end else if (nomem_i) begin
        m_wbwe = (rd_i != 0);
        m_wbrd = rd_i;
        m_wbdat = addr_i;
      end
    end
  end

  // Literal pins, set by the stimulus around one op.
  logic        pin_wb = 1'b0;
  logic [4:0]  pin_rd = '0;
  logic [63:0] pin_wdat = '0;
  logic        pin_bus = 1'b0;
  logic [63:0] pin_adr = '0;
  logic [7:0]  pin_sel = '0;
  logic        pin_bwe = 1'b0;
  logic [63:0] pin_bdat = '0;
  int          pin_blen = 0;
  int          bcnt = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    chk("busy", 64'(busy_o), 64'(m_pend));
    chk("cyc", 64'(dwb_cyc_o), 64'(m_pend));
    chk("stb", 64'(dwb_stb_o), 64'(m_pend));
    chk("wb_we", 64'(wb_we_o), 64'(m_wbwe));
    chk("wb_rd", 64'(wb_rd_o), 64'(m_wbrd));
    chk("wb_dat", wb_dat_o, m_wbdat);
    chk("fault", 64'(fault_o), 64'(m_fault));
    if (m_pend) begin
      chk("adr", dwb_adr_o, m_adr);
      chk("sel", 64'(dwb_sel_o), 64'(m_sel));
      chk("bus_we", 64'(dwb_we_o), 64'(m_we));
      chk("bus_dat", dwb_dat_o, m_dat);
    end
    if (wb_we_o && pin_wb) begin
      chk("pin_wb_rd", 64'(wb_rd_o), 64'(pin_rd));
      chk("pin_wb_dat", wb_dat_o, pin_wdat);
    end
    if (dwb_cyc_o && pin_bus) begin
      chk("pin_adr", dwb_adr_o, pin_adr);
      chk("pin_sel", 64'(dwb_sel_o), 64'(pin_sel));
      chk("pin_we", 64'(dwb_we_o), 64'(pin_bwe));
      chk("pin_bdat", dwb_dat_o, pin_bdat);
    end
    if (busy_o) begin
      bcnt++;
    end else begin
      if (bcnt != 0 && pin_blen != 0)
        chk("pin_busy_len", 64'(bcnt), 64'(pin_blen));
      bcnt = 0;
    end
  end

  task automatic op(input logic w, input logic m, input logic n,
                    input logic [1:0] sz, input logic u,
                    input logic [4:0] rd, input logic [63:0] a,
                    input logic [63:0] d);
    @(negedge clk);
    we_i = w;
    mem_i = m;
    nomem_i = n;
    xrs_rwe_i = {u, sz};
    rd_i = rd;
    addr_i = a;
    dat_i = d;
    @(negedge clk);
    we_i = 1'b0;
    mem_i = 1'b0;
    nomem_i = 1'b0;
  endtask

  task automatic resp(input int waits, input logic a,
                      input logic e, input logic [63:0] r);
    repeat (waits) @(negedge clk);
    dwb_ack_i = a;
    dwb_err_i = e;
    dwb_dat_i = r;
    @(negedge clk);
    dwb_ack_i = 1'b0;
    dwb_err_i = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic unpin();
    pin_wb = 1'b0;
    pin_bus = 1'b0;
    pin_blen = 0;
  endtask

  initial begin
    reset_i = 1'b0;
    gap(3);
    reset_i = 1'b1;
    gap(1);

    pin_wb = 1'b1; pin_rd = 5'd5; pin_wdat = 64'h1234;
    op(0, 0, 1, SZ_D, 0, 5'd5, 64'h1234, 64'h0);
    gap(2); unpin();
    op(0, 0, 1, SZ_D, 0, 5'd0, 64'h5678, 64'h0);
    gap(2);

    pin_bus = 1'b1; pin_adr = 64'h1000; pin_sel = 8'h08;
    pin_bwe = 1'b0; pin_bdat = 64'h0; pin_blen = 3;
    pin_wb = 1'b1; pin_rd = 5'd7;
    pin_wdat = 64'hFFFF_FFFF_FFFF_FF80;
    op(0, 1, 0, SZ_B, 0, 5'd7, 64'h1003, 64'h0);
    resp(2, 1, 0, 64'h0000_0000_8000_0000);
    gap(2);
    pin_wdat = 64'h80;
    op(0, 1, 0, SZ_B, 1, 5'd7, 64'h1003, 64'h0);
    resp(2, 1, 0, 64'h0000_0000_8000_0000);
    gap(2); unpin();

    pin_bus = 1'b1; pin_adr = 64'h2000; pin_sel = 8'hF0;
    pin_bwe = 1'b1; pin_bdat = 64'hDEADBEEF_DEADBEEF;
    pin_blen = 1;
    op(1, 0, 0, SZ_W, 0, 5'd3, 64'h2004, 64'hDEAD_BEEF);
    resp(0, 1, 0, 64'h1111_2222_3333_4444);
    gap(2); unpin();

    op(0, 1, 0, SZ_H, 0, 5'd8, 64'h3001, 64'h0);
    gap(2);
    op(0, 1, 0, SZ_D, 0, 5'd9, 64'h4000, 64'h0);
    resp(0, 1, 1, 64'hAAAA_BBBB_CCCC_DDDD);
    gap(2);

    op(0, 1, 0, SZ_W, 0, 5'd4, 64'h5000, 64'h0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    resp(0, 1, 0, 64'h1234_5678_9ABC_DEF0);
    gap(2);

    pin_wb = 1'b1; pin_rd = 5'd10;
    pin_wdat = 64'hFFFF_FFFF_FFFF_9876;
    op(0, 1, 0, SZ_H, 0, 5'd10, 64'h6006, 64'h0);
    resp(1, 1, 0, 64'h9876_0000_0000_0000);
    gap(2); unpin();

    pin_bus = 1'b1; pin_adr = 64'h7000; pin_sel = 8'h0C;
    pin_bwe = 1'b1; pin_bdat = 64'hA55A_A55A_A55A_A55A;
    op(1, 1, 1, SZ_H, 0, 5'd11, 64'h7002, 64'hFFFF_A55A);
    resp(0, 1, 0, 64'h0);
    gap(2); unpin();

    op(1, 0, 0, SZ_D, 0, 5'd12, 64'h7004, 64'h0);
    gap(2);
    op(0, 1, 1, SZ_D, 0, 5'd13, 64'h8000, 64'h0);
    resp(0, 1, 0, 64'h0123_4567_89AB_CDEF);
    gap(2);

    for (int k = 0; k < 40; k++) begin
      op(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
         1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
         {$urandom, $urandom}, {$urandom, $urandom});
      resp($urandom_range(0, 3), 1'b1,
           1'($urandom_range(0, 7) == 0), {$urandom, $urandom});
      gap(1);
    end

    gap(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
